// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer feeding a 1%-resolution PWM generator.
// Steps duty toward a latched target on a tick/interval schedule.
module pwm_ramp_ctrl #(
  parameter int TICK_DIV = 125_000,
  parameter int DUTY_MAX = 100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [6:0]  target_duty,
  input  logic [6:0]  step,
  input  logic [15:0] step_interval,
  input  logic [13:0] freq_in,
  input  logic        abort,
  output logic [6:0]  duty_out,
  output logic [13:0] pwm_freq_out,
  output logic        busy,
  output logic        done,
  output logic        sat
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    FINISH
  } state_e;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [6:0] DMAX = 7'(DUTY_MAX);

  state_e        state_q, state_d;
  logic [6:0]    duty_q, duty_d;
  logic [13:0]   freq_q, freq_d;
  logic          sat_q, sat_d;
  logic [6:0]    tgt_q, tgt_d;
  logic [6:0]    stp_q, stp_d;
  logic [15:0]   ivl_q, ivl_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [15:0]   icnt_q, icnt_d;

  logic          tick;
  logic [7:0]    up_sum;
  logic [7:0]    dn_diff;
  logic [6:0]    stepped;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      duty_q  <= '0;
      freq_q  <= '0;
      sat_q   <= 1'b0;
      tgt_q   <= '0;
      stp_q   <= 7'd1;
      ivl_q   <= 16'd1;
      tick_q  <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      freq_q  <= freq_d;
      sat_q   <= sat_d;
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
      ivl_q   <= ivl_d;
      tick_q  <= tick_d;
      icnt_q  <= icnt_d;
    end
  end

  // 8-bit intermediates so a step can never wrap past 0 or 127
  always_comb begin
    up_sum  = {1'b0, duty_q} + {1'b0, stp_q};
    dn_diff = {1'b0, duty_q} - {1'b0, stp_q};
    stepped = duty_q;
    unique case (1'b1)
      (duty_q < tgt_q):
        stepped = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[6:0];
      (duty_q > tgt_q):
        stepped = (dn_diff[7] || dn_diff <= {1'b0, tgt_q})
                  ? tgt_q : dn_diff[6:0];
      default:
        stepped = duty_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    freq_d  = freq_q;
    sat_d   = sat_q;
    tgt_d   = tgt_q;
    stp_d   = stp_q;
    ivl_d   = ivl_q;
    tick_d  = tick_q;
    icnt_d  = icnt_q;
    tick    = (tick_q == TICK_LAST);
    if (abort) begin
      state_d = IDLE;
      duty_d  = '0;
      tick_d  = '0;
      icnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            tgt_d   = (target_duty > DMAX) ? DMAX : target_duty;
            stp_d   = (step == 7'd0) ? 7'd1 : step;
            ivl_d   = (step_interval == 16'd0) ? 16'd1 : step_interval;
            freq_d  = freq_in;
            sat_d   = (target_duty > DMAX);
            tick_d  = '0;
            icnt_d  = '0;
            state_d = (tgt_d == duty_q) ? FINISH : RAMP;
          end
        end
        RAMP: begin
          tick_d = tick ? '0 : tick_q + TW'(1);
          if (tick) begin
            if (icnt_q == ivl_q - 16'd1) begin
              icnt_d = '0;
              duty_d = stepped;
              if (stepped == tgt_q) state_d = FINISH;
            end else begin
              icnt_d = icnt_q + 16'd1;
            end
          end
        end
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    duty_out     = duty_q;
    pwm_freq_out = freq_q;
    sat          = sat_q;
    busy         = (state_q == RAMP);
    done         = (state_q == FINISH);
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with TICK_DIV=10.
// Expected duty trajectories come from a small integer step model.
module tb_pwm_ramp_ctrl;

  localparam int TD = 10;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [6:0]  target_duty;
  logic [6:0]  step;
  logic [15:0] step_interval;
  logic [13:0] freq_in;
  logic        abort;
  logic [6:0]  duty_out;
  logic [13:0] pwm_freq_out;
  logic        busy;
  logic        done;
  logic        sat;

  int errs = 0;
  int checks = 0;
  int cur = 0;

  pwm_ramp_ctrl #(.TICK_DIV(TD), .DUTY_MAX(100)) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .target_duty(target_duty),
    .step(step),
    .step_interval(step_interval),
    .freq_in(freq_in),
    .abort(abort),
    .duty_out(duty_out),
    .pwm_freq_out(pwm_freq_out),
    .busy(busy),
    .done(done),
    .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic start_pulse(input int t, input int s, input int iv,
                             input int f);
    @(negedge clk);
    target_duty   = 7'(t);
    step          = 7'(s);
    step_interval = 16'(iv);
    freq_in       = 14'(f);
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one start, checking duty/busy/done every cycle against the model.
  task automatic do_ramp(input int t, input int s, input int iv,
                         input int f, input int esat);
    int et, es, ei, per, md, fin;
    et  = (t > 100) ? 100 : t;
    es  = (s == 0) ? 1 : s;
    ei  = (iv == 0) ? 1 : iv;
    per = ei * TD;
    md  = cur;
    fin = (md == et) ? 0 : -1;
    start_pulse(t, s, iv, f);
    for (int k = 0; k < 3000; k++) begin
      if (k > 0) @(negedge clk);
      if (fin < 0 && k > 0 && (k % per) == 0) begin
        if (md < et) md = (md + es >= et) ? et : md + es;
        else         md = (md - es <= et) ? et : md - es;
        if (md == et) fin = k;
      end
      chk("duty", int'(duty_out), md);
      chk("busy", int'(busy), (fin < 0) ? 1 : 0);
      chk("done", int'(done), (fin == k) ? 1 : 0);
      if (fin >= 0 && k == fin + 1) break;
    end
    chk("ramp_ends", (fin >= 0) ? 1 : 0, 1);
    chk("freq", int'(pwm_freq_out), f);
    chk("sat", int'(sat), esat);
    cur = et;
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    target_duty = '0;
    step = '0;
    step_interval = '0;
    freq_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_duty", int'(duty_out), 0);
    chk("rst_freq", int'(pwm_freq_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sat", int'(sat), 0);
    rstn = 1'b1;

    do_ramp(50, 10, 2, 1000, 0);
    do_ramp(5, 20, 1, 1000, 0);
    do_ramp(95, 45, 1, 1000, 0);
    do_ramp(120, 0, 0, 3000, 1);
    do_ramp(40, 60, 1, 3000, 0);
    do_ramp(40, 5, 1, 3000, 0);

    // abort with a simultaneous start mid-ramp at duty 30
    start_pulse(0, 10, 1, 4000);
    repeat (12) @(negedge clk);
    chk("ab_pre_duty", int'(duty_out), 30);
    chk("ab_pre_busy", int'(busy), 1);
    abort = 1'b1;
    start = 1'b1;
    target_duty = 7'd90;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("ab_duty", int'(duty_out), 0);
    chk("ab_busy", int'(busy), 0);
    chk("ab_done", int'(done), 0);
    chk("ab_freq", int'(pwm_freq_out), 4000);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("ab_idle_duty", int'(duty_out), 0);
      chk("ab_idle_busy", int'(busy), 0);
      chk("ab_idle_done", int'(done), 0);
    end
    cur = 0;

    // asynchronous reset between edges at duty 20
    start_pulse(40, 20, 1, 2000);
    repeat (12) @(negedge clk);
    chk("ar_pre_duty", int'(duty_out), 20);
    #2 rstn = 1'b0;
    #1;
    chk("ar_duty", int'(duty_out), 0);
    chk("ar_freq", int'(pwm_freq_out), 0);
    chk("ar_busy", int'(busy), 0);
    @(negedge clk);
    rstn = 1'b1;
    cur = 0;
    do_ramp(10, 10, 1, 500, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
